timer_ctrl: RTL and testbench

Memory-mapped countdown timer controller that sequences a WIDTH-bit down-counter datapath. The processor bus programs it through three word registers: CTRL, PRESET and COUNT. It raises an interrupt on expiry. It sits on the system bridge beside the other peripherals, and its irq drives the CPU's external interrupt input.

---
 rtl/timer_ctrl_pkg.sv | 36 +++
 rtl/timer_ctrl_if.sv | 12 +
 rtl/timer_ctrl_counter.sv | 29 ++
 rtl/timer_ctrl.sv | 130 +++++++++++++
 tb/tb_timer_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared constants and types for the countdown timer controller:
// register map, CTRL field layout, timer modes and FSM state encoding.
package timer_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_BITS     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    // Modes 2 and 3 fall back to one-shot behaviour.
    function automatic logic is_reload(input ctrl_t c);
        return (c.mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Processor bus seen by the timer: single-cycle writes, combinational reads,
// plus the interrupt line back to the CPU.
interface timer_ctrl_if #(parameter int WIDTH = 32);
    logic             we;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             irq;

    modport master (output we, addr, wdata, input rdata, irq);
    modport slave  (input we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/timer_ctrl_counter.sv
// WIDTH-bit loadable down-counter; a decrement at zero holds zero.
module timer_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count register: load has priority over decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= ZERO;
        end else if (load) begin
            q <= d;
        end else if (dec && (q != ZERO)) begin
            q <= q - ONE;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, sequencing FSM
// and interrupt flag around a loadable down-counter.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    ctrl_t            ctrl_r;
    logic [WIDTH-1:0] preset_r;
    logic             flag_r;

    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] load_val_s;
    logic             load_s;
    logic             dec_s;
    logic             ctrl_wr_s;
    logic             preset_wr_s;
    logic             expire_s;

    // Bus write decode and expiry detection.
    always_comb begin
        ctrl_wr_s   = bus.we && (bus.addr == ADDR_CTRL);
        preset_wr_s = bus.we && (bus.addr == ADDR_PRESET);
        expire_s    = (state_r == CNT) && ctrl_r.en && (count_s <= ONE);
    end

    // Counter controls: LOAD copies PRESET, expiry forces zero, else count down.
    always_comb begin
        load_s     = 1'b0;
        dec_s      = 1'b0;
        load_val_s = ZERO;
        case (state_r)
            LOAD: begin
                load_s     = 1'b1;
                load_val_s = preset_r;
            end
            CNT: begin
                if (expire_s) begin
                    load_s = 1'b1;
                end else if (ctrl_r.en) begin
                    dec_s = 1'b1;
                end else begin
                    dec_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    timer_counter #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .dec   (dec_s),
        .d     (load_val_s),
        .q     (count_s)
    );

    // FSM, CTRL/PRESET registers and interrupt flag; a CTRL write beats any
    // same-cycle flag set or end-of-run EN clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            ctrl_r   <= '{im: 1'b0, mode: 2'b00, en: 1'b0};
            preset_r <= ZERO;
            flag_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE:    state_r <= ctrl_r.en ? LOAD : IDLE;
                LOAD:    state_r <= CNT;
                CNT: begin
                    if (!ctrl_r.en) begin
                        state_r <= IDLE;
                    end else if (expire_s) begin
                        state_r <= INT;
                    end else begin
                        state_r <= CNT;
                    end
                end
                INT:     state_r <= IDLE;
                default: state_r <= IDLE;
            endcase

            if (ctrl_wr_s) begin
                ctrl_r <= ctrl_t'(bus.wdata[CTRL_BITS-1:0]);
                flag_r <= 1'b0;
            end else if (state_r == INT) begin
                if (is_reload(ctrl_r)) begin
                    flag_r <= 1'b0;
                end else begin
                    ctrl_r.en <= 1'b0;
                end
            end else if (expire_s) begin
                flag_r <= 1'b1;
            end else begin
                flag_r <= flag_r;
            end

            if (preset_wr_s) begin
                preset_r <= bus.wdata;
            end else begin
                preset_r <= preset_r;
            end
        end
    end

    // Combinational read mux; unused CTRL bits and the reserved slot read 0.
    always_comb begin
        case (bus.addr)
            ADDR_CTRL:   bus.rdata = {{(WIDTH-CTRL_BITS){1'b0}}, ctrl_r};
            ADDR_PRESET: bus.rdata = preset_r;
            ADDR_COUNT:  bus.rdata = count_s;
            default:     bus.rdata = ZERO;
        endcase
    end

    assign bus.irq = ctrl_r.im & flag_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios against fixed values
// and a randomized run against a cycle-level reference model.
module tb_timer_ctrl;

    localparam int W = 32;
    localparam int PH_WAIT = 0, PH_ARM = 1, PH_RUN = 2, PH_DONE = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    timer_ctrl_if #(.WIDTH(W)) bus();
    timer_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int          ph;
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count;
    logic        m_flag;

    // Reference model: one clock of the timer's documented behaviour.
    task automatic model_step(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
        logic en;
        logic [1:0] mode;
        if (r) begin
            ph = PH_WAIT; m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
        end else begin
            en = m_ctrl[0];
            mode = m_ctrl[2:1];
            case (ph)
                PH_WAIT: if (en) ph = PH_ARM;
                PH_ARM: begin m_count = m_preset; ph = PH_RUN; end
                PH_RUN: begin
                    if (!en) ph = PH_WAIT;
                    else if (m_count > 32'd1) m_count = m_count - 32'd1;
                    else begin m_count = 32'd0; m_flag = 1'b1; ph = PH_DONE; end
                end
                default: begin
                    ph = PH_WAIT;
                    if (mode == 2'd1) m_flag = 1'b0;
                    else m_ctrl[0] = 1'b0;
                end
            endcase
            if (w && a == 2'd0) begin m_ctrl = d[3:0]; m_flag = 1'b0; end
            if (w && a == 2'd1) m_preset = d;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
        reset = r; bus.we = w; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        model_step(r, w, a, d);
        #1;
        reset = 1'b0; bus.we = 1'b0; bus.wdata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.addr = a;
        #1;
        v = bus.rdata;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 2'd2, 32'd0);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        tick(1'b1, 1'b0, 2'd0, 32'd0);
        tick(1'b1, 1'b1, 2'd0, 32'hF);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0", a, v); end
        end
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        int exp_cnt[4] = '{3, 2, 1, 0};
        tick(1'b1, 1'b0, 2'd0, 32'd0);
        tick(1'b0, 1'b1, 2'd1, 32'd3);
        tick(1'b0, 1'b1, 2'd0, 32'h9);
        rd(2'd0, v);
        checks++;
        if (v !== 32'h9) begin errors++; $display("FAIL oneshot_ctrl_rd: got %h expected 9", v); end
        idle();
        for (int k = 0; k < 4; k++) begin
            idle();
            rd(2'd2, v);
            checks++;
            if (v !== 32'(exp_cnt[k])) begin errors++; $display("FAIL oneshot_count[%0d]: got %0d expected %0d", k, v, exp_cnt[k]); end
            checks++;
            if (bus.irq !== (k == 3)) begin errors++; $display("FAIL oneshot_irq[%0d]: got %b expected %b", k, bus.irq, (k == 3)); end
        end
        idle();
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl_after: got %h expected 8", v); end
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_hold: got %b expected 1", bus.irq); end
        tick(1'b0, 1'b1, 2'd0, 32'h8);
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear: got %b expected 0", bus.irq); end
    endtask

    task automatic test_reload();
        logic [31:0] v, c;
        logic exp_irq;
        logic [31:0] exp_c;
        int pat[5] = '{2, 1, 0, 0, 0};
        tick(1'b1, 1'b0, 2'd0, 32'd0);
        tick(1'b0, 1'b1, 2'd1, 32'd2);
        tick(1'b0, 1'b1, 2'd0, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            idle();
            rd(2'd2, v);
            rd(2'd0, c);
            exp_irq = (k >= 4) && (((k - 4) % 5) == 0);
            exp_c = (k >= 2) ? 32'(pat[(k - 2) % 5]) : 32'd0;
            checks++;
            if (bus.irq !== exp_irq) begin errors++; $display("FAIL reload_irq[E%0d]: got %b expected %b", k, bus.irq, exp_irq); end
            checks++;
            if (v !== exp_c) begin errors++; $display("FAIL reload_count[E%0d]: got %0d expected %0d", k, v, exp_c); end
            checks++;
            if (c !== 32'hB) begin errors++; $display("FAIL reload_ctrl[E%0d]: got %h expected b", k, c); end
        end
    endtask

    task automatic test_disable();
        logic [31:0] v;
        logic found;
        found = 1'b0;
        tick(1'b1, 1'b0, 2'd0, 32'd0);
        tick(1'b0, 1'b1, 2'd1, 32'd10);
        tick(1'b0, 1'b1, 2'd0, 32'h9);
        for (int i = 0; i < 20 && !found; i++) begin
            idle();
            rd(2'd2, v);
            if (v == 32'd7) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL disable_reach7: got %0d expected 7 within 20 cycles", v); end
        tick(1'b0, 1'b1, 2'd0, 32'h8);
        for (int i = 0; i < 5; i++) begin
            idle();
            rd(2'd2, v);
            checks++;
            if (v !== 32'd6) begin errors++; $display("FAIL disable_hold[%0d]: got %0d expected 6", i, v); end
            checks++;
            if (bus.irq !== 1'b0) begin errors++; $display("FAIL disable_irq[%0d]: got %b expected 0", i, bus.irq); end
        end
        tick(1'b0, 1'b1, 2'd0, 32'h9);
        idle();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd6) begin errors++; $display("FAIL reenable_E1: got %0d expected 6", v); end
        idle();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd10) begin errors++; $display("FAIL reenable_reload: got %0d expected 10", v); end
    endtask

    task automatic test_zero_mask();
        logic [31:0] v;
        tick(1'b1, 1'b0, 2'd0, 32'd0);
        tick(1'b0, 1'b1, 2'd1, 32'd0);
        tick(1'b0, 1'b1, 2'd0, 32'h1);
        idle();
        idle();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", v); end
        idle();
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL zero_masked_irq: got %b expected 0", bus.irq); end
        idle();
        rd(2'd0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL zero_int_clears_en: got %h expected 0", v); end
        tick(1'b0, 1'b1, 2'd0, 32'h8);
        idle();
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL zero_unmask_irq: got %b expected 0", bus.irq); end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        tick(1'b1, 1'b0, 2'd0, 32'd0);
        tick(1'b0, 1'b1, 2'd1, 32'd2);
        tick(1'b0, 1'b1, 2'd0, 32'h9);
        idle(); idle(); idle();
        tick(1'b0, 1'b1, 2'd0, 32'hD);
        rd(2'd0, v);
        checks++;
        if (v !== 32'hD) begin errors++; $display("FAIL coll_ctrl_wins: got %h expected d", v); end
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL coll_flag_clear: got %b expected 0", bus.irq); end
        idle();
        rd(2'd0, v);
        checks++;
        if (v !== 32'hC) begin errors++; $display("FAIL coll_int_en_clear: got %h expected c", v); end
        tick(1'b1, 1'b0, 2'd0, 32'd0);
        tick(1'b0, 1'b1, 2'd1, 32'd1);
        tick(1'b0, 1'b1, 2'd0, 32'h9);
        idle(); idle(); idle();
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL coll2_expire: got %b expected 1", bus.irq); end
        tick(1'b0, 1'b1, 2'd0, 32'h9);
        rd(2'd0, v);
        checks++;
        if (v !== 32'h9 || bus.irq !== 1'b0) begin errors++; $display("FAIL coll2_int_write: got ctrl=%h irq=%b expected ctrl=9 irq=0", v, bus.irq); end
        idle(); idle(); idle();
        checks++;
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL coll2_rerun: got %b expected 1", bus.irq); end
    endtask

    task automatic test_ignored_and_reset();
        logic [31:0] v;
        tick(1'b1, 1'b0, 2'd0, 32'd0);
        tick(1'b0, 1'b1, 2'd1, 32'd5);
        tick(1'b0, 1'b1, 2'd0, 32'hB);
        idle(); idle(); idle();
        tick(1'b0, 1'b1, 2'd2, 32'h55);
        rd(2'd2, v);
        checks++;
        if (v !== 32'd3) begin errors++; $display("FAIL count_write_ignored: got %0d expected 3", v); end
        tick(1'b0, 1'b1, 2'd3, 32'hFFFF);
        rd(2'd3, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL reserved_read: got %h expected 0", v); end
        tick(1'b1, 1'b1, 2'd0, 32'hF);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL midreset_reg%0d: got %h expected 0", a, v); end
        end
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", bus.irq); end
    endtask

    task automatic test_random();
        logic [31:0] v, d;
        logic r, w, exp_irq;
        logic [1:0] a;
        tick(1'b1, 1'b0, 2'd0, 32'd0);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(99) == 0);
            w = ($urandom_range(99) < 35);
            a = 2'($urandom_range(3));
            d = (a == 2'd1) ? 32'($urandom_range(6)) : $urandom;
            tick(r, w, a, d);
            for (int k = 0; k < 4; k++) begin
                rd(2'(k), v);
                checks++;
                if (v !== model_read(2'(k))) begin
                    errors++;
                    $display("FAIL rand_reg%0d[%0d]: got %h expected %h", k, i, v, model_read(2'(k)));
                end
            end
            exp_irq = m_ctrl[3] & m_flag;
            checks++;
            if (bus.irq !== exp_irq) begin errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, bus.irq, exp_irq); end
        end
    endtask

    initial begin
        bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
        ph = PH_WAIT; m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
        test_reset();
        test_oneshot();
        test_reload();
        test_disable();
        test_zero_mask();
        test_collision();
        test_ignored_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
